// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the ahb_slave_mem responder:
// transfer types, size codes, response codes and the slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data-phase sequencer of the responder.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite link between the bus fabric (master side: request plus the muxed
// hready) and one responder (slave side: hreadyout/hresp/hrdata).
interface ahb_slave_mem_if;
    import ahb_pkg::*;

    logic        hsel;
    logic [31:0] haddr;
    htrans_t     htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe generator: maps an AHB size and the two low address bits
// onto the four byte lanes of a 32-bit word. Oversized transfers use all lanes.
module ahb_strb_gen
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        strb = 4'b1111;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr_lo;
            SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-organised register array, with
// programmable wait states. Define AHB_SLV_ERR_EN for the two-cycle ERROR response.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0,
    parameter bit INIT_ZERO   = 1'b1
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_mem_if.slave bus
);

    localparam int         AW        = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt;
    logic [AW+1:0] lat_addr;
    logic          lat_write;
    logic [2:0]    lat_size;
    logic [31:0]   mem [MEM_DEPTH];

    logic          ready;
    logic          resp;
    logic [31:0]   rdata;
    logic          accept;
    logic          req_err;
    logic          commit;
    logic [3:0]    strb;
    logic [AW-1:0] word_idx;
    logic [31:0]   wr_word;
    logic          unused_bits;

    // Our own stall gates acceptance so an address phase is only taken while
    // this responder can start a new data phase.
    assign accept   = bus.hsel & bus.htrans[1] & bus.hready & ready;
    assign word_idx = lat_addr[AW+1:2];

`ifdef AHB_SLV_ERR_EN
    assign req_err = (bus.hsize > SIZE_WORD)
                   | ((bus.hsize == SIZE_HALF) & bus.haddr[0])
                   | ((bus.hsize == SIZE_WORD) & (bus.haddr[1:0] != 2'b00))
                   | (|bus.haddr[31:AW+2]);
    assign unused_bits = bus.htrans[0];
`else
    assign req_err     = 1'b0;
    assign unused_bits = ^{bus.haddr[31:AW+2], bus.htrans[0]};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    if (req_err)               state_nxt = S_ERR1;
                    else if (WAIT_STATES == 0) state_nxt = S_DATA;
                    else                       state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_DATA;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        resp  = HRESP_OKAY;
        rdata = '0;
        case (state)
            S_WAIT: begin
                ready = 1'b0;
                if (!lat_write) rdata = mem[word_idx];
            end
            S_DATA: if (!lat_write) rdata = mem[word_idx];
            S_ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
            end
            S_ERR2:  resp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign bus.hreadyout = ready;
    assign bus.hresp     = resp;
    assign bus.hrdata    = rdata;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge hclk) begin
        if (hreset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= SIZE_BYTE;
        end else if (accept) begin
            wait_cnt  <= WAIT_LOAD;
            lat_addr  <= bus.haddr[AW+1:0];
            lat_write <= bus.hwrite;
            lat_size  <= bus.hsize;
        end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    ahb_strb_gen u_strb (
        .size    (lat_size),
        .addr_lo (lat_addr[1:0]),
        .strb    (strb)
    );

    // Merge the selected lanes of hwdata into the current word.
    always_comb begin
        wr_word = mem[word_idx];
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) wr_word[8*i +: 8] = bus.hwdata[8*i +: 8];
        end
    end

    assign commit = (state == S_DATA) & lat_write;

    // NOTE: the array only gets a reset branch when INIT_ZERO asks for it; a
    // reset-free array lets synthesis map it to plain storage without clear logic.
    generate
        if (INIT_ZERO) begin : g_mem_clr
            always_ff @(posedge hclk) begin
                if (hreset) begin
                    for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
                end else if (commit) begin
                    mem[word_idx] <= wr_word;
                end
            end
        end else begin : g_mem_keep
            always_ff @(posedge hclk) begin
                if (!hreset && commit) mem[word_idx] <= wr_word;
            end
        end
    endgenerate

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a zero-wait instance (16 words, cleared at
// reset) and a three-wait instance (1024 words, not cleared) on separate buses.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_bad    = 0;

    ahb_slave_mem_if b0 ();
    ahb_slave_mem_if b3 ();

    logic        tgt;
    logic        t_sel;
    logic [31:0] t_addr;
    htrans_t     t_trans;
    logic        t_write;
    logic [2:0]  t_size;
    logic [31:0] t_wdata;
    logic        r_ready;
    logic        r_resp;
    logic [31:0] r_rdata;

    assign b0.hsel   = t_sel & ~tgt;
    assign b3.hsel   = t_sel & tgt;
    assign b0.haddr  = t_addr;
    assign b3.haddr  = t_addr;
    assign b0.htrans = t_trans;
    assign b3.htrans = t_trans;
    assign b0.hwrite = t_write;
    assign b3.hwrite = t_write;
    assign b0.hsize  = t_size;
    assign b3.hsize  = t_size;
    assign b0.hwdata = t_wdata;
    assign b3.hwdata = t_wdata;
    assign b0.hready = b0.hreadyout;
    assign b3.hready = b3.hreadyout;

    assign r_ready = tgt ? b3.hreadyout : b0.hreadyout;
    assign r_resp  = tgt ? b3.hresp     : b0.hresp;
    assign r_rdata = tgt ? b3.hrdata    : b0.hrdata;

    ahb_slave_mem #(.MEM_DEPTH(16), .WAIT_STATES(0), .INIT_ZERO(1'b1)) u0 (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (b0)
    );

    ahb_slave_mem #(.MEM_DEPTH(1024), .WAIT_STATES(3), .INIT_ZERO(1'b0)) u3 (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (b3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        t_sel   = 1'b0;
        t_trans = TRANS_IDLE;
        t_write = 1'b0;
        t_addr  = '0;
        t_size  = SIZE_WORD;
    endtask

    task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] s);
        t_sel   = 1'b1;
        t_trans = TRANS_NONSEQ;
        t_write = w;
        t_addr  = a;
        t_size  = s;
    endtask

    // One isolated transfer: returns the final data-phase sample, the number of
    // stalled cycles and the response seen in the first stalled cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic rsp, output int waits, output logic first_resp);
        addr_phase(w, a, s);
        cycle();
        bus_idle();
        t_wdata    = wd;
        waits      = 0;
        first_resp = r_resp;
        while (!r_ready && waits < 40) begin
            waits++;
            cycle();
        end
        check("xfer_ready", 32'(r_ready), 32'd1);
        rd  = r_rdata;
        rsp = r_resp;
        cycle();
    endtask

    logic [31:0] rd;
    logic        rsp;
    logic        fr;
    int          waits;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tgt     = 1'b0;
        t_wdata = '0;
        bus_idle();
        hreset = 1'b1;
        repeat (3) cycle();
        hreset = 1'b0;

        check("rst_ready0", 32'(b0.hreadyout), 32'd1);
        check("rst_resp0",  32'(b0.hresp),     32'd0);
        check("rst_rdata0", b0.hrdata,         32'd0);
        check("rst_ready3", 32'(b3.hreadyout), 32'd1);
        check("rst_resp3",  32'(b3.hresp),     32'd0);
        check("rst_rdata3", b3.hrdata,         32'd0);

        // Pipelined write then read of the same word, zero wait states.
        addr_phase(1'b1, 32'h10, SIZE_WORD);
        cycle();
        addr_phase(1'b0, 32'h10, SIZE_WORD);
        t_wdata = 32'hDEAD_BEEF;
        check("b2b_wr_ready", 32'(r_ready), 32'd1);
        cycle();
        bus_idle();
        t_wdata = '0;
        check("b2b_rd_ready", 32'(r_ready), 32'd1);
        check("b2b_rd_data",  r_rdata,      32'hDEAD_BEEF);
        check("b2b_rd_resp",  32'(r_resp),  32'd0);
        cycle();
        check("b2b_idle_data",  r_rdata,      32'd0);
        check("b2b_idle_ready", 32'(r_ready), 32'd1);

        // Byte and halfword lane merging.
        xfer(1'b1, 32'h10, SIZE_WORD, 32'h1122_3344, rd, rsp, waits, fr);
        xfer(1'b1, 32'h13, SIZE_BYTE, 32'hAAAA_AAAA, rd, rsp, waits, fr);
        xfer(1'b0, 32'h10, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("byte_merge", rd, 32'hAA22_3344);
        xfer(1'b1, 32'h10, SIZE_HALF, 32'h5566_5566, rd, rsp, waits, fr);
        xfer(1'b0, 32'h10, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("half_merge", rd, 32'hAA22_5566);

        // BUSY and deselected writes must be ignored.
        t_sel = 1'b1; t_trans = TRANS_BUSY; t_write = 1'b1;
        t_addr = 32'h10; t_size = SIZE_WORD; t_wdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("busy_ready", 32'(r_ready), 32'd1);
            check("busy_resp",  32'(r_resp),  32'd0);
        end
        t_sel = 1'b0; t_trans = TRANS_NONSEQ;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("nosel_ready", 32'(r_ready), 32'd1);
            check("nosel_resp",  32'(r_resp),  32'd0);
        end
        bus_idle();
        xfer(1'b0, 32'h10, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("ignored_wr", rd, 32'hAA22_5566);

        // Unaligned word and out-of-range address.
        xfer(1'b1, 32'h2, SIZE_WORD, 32'hCAFE_F00D, rd, rsp, waits, fr);
`ifdef AHB_SLV_ERR_EN
        check("unal_waits", 32'(waits), 32'd1);
        check("unal_err1",  32'(fr),    32'd1);
        check("unal_err2",  32'(rsp),   32'd1);
        xfer(1'b0, 32'h0, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("unal_nowr", rd, 32'h0);
`else
        check("unal_waits", 32'(waits), 32'd0);
        check("unal_resp",  32'(rsp),   32'd0);
        xfer(1'b0, 32'h0, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("unal_align", rd, 32'hCAFE_F00D);
`endif
        xfer(1'b1, 32'h40, SIZE_WORD, 32'h0BAD_C0DE, rd, rsp, waits, fr);
`ifdef AHB_SLV_ERR_EN
        check("oor_waits", 32'(waits), 32'd1);
        check("oor_err1",  32'(fr),    32'd1);
        check("oor_err2",  32'(rsp),   32'd1);
        xfer(1'b0, 32'h0, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("oor_nowr", rd, 32'h0);
`else
        check("oor_resp", 32'(rsp), 32'd0);
        xfer(1'b0, 32'h0, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("oor_wrap", rd, 32'h0BAD_C0DE);
`endif

        // Three wait states.
        tgt = 1'b1;
        xfer(1'b1, 32'h20, SIZE_WORD, 32'h1234_5678, rd, rsp, waits, fr);
        check("ws_wr_waits", 32'(waits), 32'd3);
        xfer(1'b0, 32'h20, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("ws_rd_waits", 32'(waits), 32'd3);
        check("ws_rd_data",  rd,         32'h1234_5678);
        check("ws_rd_resp",  32'(rsp),   32'd0);
        check("ws_idle_ready", 32'(r_ready), 32'd1);

        // Reset during the wait phase of a write drops the write.
        addr_phase(1'b1, 32'h20, SIZE_WORD);
        cycle();
        bus_idle();
        t_wdata = 32'hFFFF_FFFF;
        check("rst_mid_stall", 32'(r_ready), 32'd0);
        cycle();
        hreset = 1'b1;
        cycle();
        hreset  = 1'b0;
        t_wdata = '0;
        check("rst_mid_ready", 32'(r_ready), 32'd1);
        check("rst_mid_resp",  32'(r_resp),  32'd0);
        check("rst_mid_rdata", r_rdata,      32'd0);
        xfer(1'b0, 32'h20, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("rst_mid_kept", rd, 32'h1234_5678);
        tgt = 1'b0;
        xfer(1'b0, 32'h10, SIZE_WORD, 32'h0, rd, rsp, waits, fr);
        check("rst_cleared", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
